// File: rtl/piso_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_sched
// Purpose  : Round-robin transmit scheduler that time-shares one LSB-first
//            parallel-in/serial-out shift register between NREQ requesters.
//            Each frame is one LOAD cycle, WIDTH-1 SHIFT cycles and
//            GAP idle cycles. Framing strobes are delayed by one cycle so
//            that they line up with the registered serial output of the piso.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous reset, active low
//            req        - per-requester level request
//            data       - requester i word at [i*WIDTH +: WIDTH]
//            ack        - one-hot grant pulse during the LOAD cycle
//            busy       - scheduler is not idle
//            piso_in    - parallel word to the piso
//            piso_sh    - piso control (0 = load, 1 = shift)
//            bit_valid  - piso output carries a frame bit
//            bit_first  - frame bit 0 on the piso output
//            bit_last   - frame bit WIDTH-1 on the piso output
//            bit_src    - owner of the bit currently on the piso output
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int GAP   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [WIDTH-1:0]        piso_in,
    output logic                    piso_sh,
    output logic                    bit_valid,
    output logic                    bit_first,
    output logic                    bit_last,
    output logic [1:0]              bit_src
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_grant;
    logic [1:0]         r_last_grant;
    logic [1:0]         w_pick;
    logic               w_any;
    logic               w_decide;
    logic               w_cnt_zero;
    logic [3:0]         w_req4;
    logic [2:0]         w_idx;
    logic [3:0]         w_ack4;
    logic [WIDTH-1:0]   w_words [4];

    // Requests and words are widened to four slots so that a 2-bit grant
    // index selects them without width mismatch for any NREQ.
    assign w_req4 = 4'(req);

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        if (gi < NREQ) begin : g_used
            assign w_words[gi] = data[gi*WIDTH +: WIDTH];
        end else begin : g_unused
            assign w_words[gi] = '0;
        end
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last_grant;
        w_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = 3'(r_last_grant) + 3'(k);
            if (w_idx >= 3'(NREQ)) begin
                w_idx = w_idx - 3'(NREQ);
            end
            if (!w_any && w_req4[w_idx[1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[1:0];
            end
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    // Next-state logic; r_cnt counts down the remaining SHIFT or GAP cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_decide    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_decide = 1'b1;
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = CNT_W'(WIDTH - 2);
            end
            S_SHIFT: begin
                if (w_cnt_zero) begin
                    if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = CNT_W'(GAP - 1);
                    end else begin
                        w_decide = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_decide = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_decide) begin
            w_state_nxt = w_any ? S_LOAD : S_IDLE;
        end
    end

    // Moore outputs: combinational from state so an asynchronous reset
    // clears them in the same cycle.
    assign w_ack4 = 4'b0001 << r_grant;

    always_comb begin
        ack     = '0;
        piso_in = '0;
        piso_sh = 1'b0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_LOAD: begin
                ack     = w_ack4[NREQ-1:0];
                piso_in = w_words[r_grant];
            end
            S_SHIFT: begin
                piso_sh = 1'b1;
            end
            default: begin
                piso_sh = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_last_grant <= 2'(NREQ - 1);
            bit_valid    <= 1'b0;
            bit_first    <= 1'b0;
            bit_last     <= 1'b0;
            bit_src      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_decide && w_any) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            // One cycle behind the state, like the piso's registered output.
            bit_valid <= (r_state == S_LOAD) || (r_state == S_SHIFT);
            bit_first <= (r_state == S_LOAD);
            bit_last  <= (r_state == S_SHIFT) && w_cnt_zero;
            bit_src   <= r_grant;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_sched
// Purpose  : Directed self-checking bench for piso_tx_sched. Two instances
//            (GAP=1 and GAP=0) each drive a small behavioural piso so the
//            serial bit stream can be compared against the loaded words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // GAP = 1 instance
    logic       reset_g1;
    logic [1:0] req_g1;
    logic [7:0] data_g1;
    logic [1:0] ack_g1;
    logic       busy_g1;
    logic [3:0] pin_g1;
    logic       sh_g1;
    logic       v_g1, f_g1, l_g1;
    logic [1:0] src_g1;

    // GAP = 0 instance
    logic       reset_g0;
    logic [1:0] req_g0;
    logic [7:0] data_g0;
    logic [1:0] ack_g0;
    logic       busy_g0;
    logic [3:0] pin_g0;
    logic       sh_g0;
    logic       v_g0, f_g0, l_g0;
    logic [1:0] src_g0;

    piso_tx_sched #(.WIDTH(4), .NREQ(2), .GAP(1)) dut_g1 (
        .clk(clk), .reset(reset_g1), .req(req_g1), .data(data_g1),
        .ack(ack_g1), .busy(busy_g1), .piso_in(pin_g1), .piso_sh(sh_g1),
        .bit_valid(v_g1), .bit_first(f_g1), .bit_last(l_g1), .bit_src(src_g1)
    );

    piso_tx_sched #(.WIDTH(4), .NREQ(2), .GAP(0)) dut_g0 (
        .clk(clk), .reset(reset_g0), .req(req_g0), .data(data_g0),
        .ack(ack_g0), .busy(busy_g0), .piso_in(pin_g0), .piso_sh(sh_g0),
        .bit_valid(v_g0), .bit_first(f_g0), .bit_last(l_g0), .bit_src(src_g0)
    );

    // Behavioural LSB-first piso driven by each scheduler.
    logic [3:0] sr_g1, sr_g0;
    logic       out_g1, out_g0;
    always @(posedge clk) begin
        sr_g1 <= sh_g1 ? (sr_g1 >> 1) : pin_g1;
        sr_g0 <= sh_g0 ? (sr_g0 >> 1) : pin_g0;
    end
    assign out_g1 = sr_g1[0];
    assign out_g0 = sr_g0[0];

    task automatic pulse_reset_g1();
        @(negedge clk);
        reset_g1 = 1'b0;
        req_g1   = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] w;
        w = 4'hA;
        reset_g1 = 1'b0;
        reset_g0 = 1'b0;
        req_g0   = 2'b00;
        data_g0  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            req_g1  = 2'($urandom_range(1, 3));
            data_g1 = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({ack_g1, busy_g1, sh_g1, pin_g1, v_g1, f_g1, l_g1, src_g1} !== 13'h0) begin
                errors++;
                $display("FAIL reset_vals got %h exp 0",
                         {ack_g1, busy_g1, sh_g1, pin_g1, v_g1, f_g1, l_g1, src_g1});
            end
        end
        req_g1   = 2'b01;
        data_g1  = 8'h0A;
        reset_g1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ack_g1 !== ((c == 0) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL reset_ack c=%0d got %b", c, ack_g1);
            end
            checks++;
            if (pin_g1 !== ((c == 0) ? w : 4'h0)) begin
                errors++; $display("FAIL reset_pin c=%0d got %h", c, pin_g1);
            end
            checks++;
            if (busy_g1 !== (c <= 4)) begin
                errors++; $display("FAIL reset_busy c=%0d got %b exp %b", c, busy_g1, (c <= 4));
            end
            checks++;
            if (sh_g1 !== (c >= 1 && c <= 3)) begin
                errors++; $display("FAIL reset_sh c=%0d got %b", c, sh_g1);
            end
            checks++;
            if (v_g1 !== (c >= 1 && c <= 4)) begin
                errors++; $display("FAIL reset_valid c=%0d got %b", c, v_g1);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({out_g1, f_g1, l_g1, src_g1} !== {w[c-1], c == 1, c == 4, 2'd0}) begin
                    errors++;
                    $display("FAIL reset_bit c=%0d got out/first/last/src %b%b%b%0d exp %b%b%b0",
                             c, out_g1, f_g1, l_g1, src_g1, w[c-1], c == 1, c == 4);
                end
            end
            if (c == 1) req_g1 = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] words [2];
        int f, j, s;
        words[0] = 4'h3;
        words[1] = 4'hC;
        pulse_reset_g1();
        req_g1   = 2'b11;
        data_g1  = {words[1], words[0]};
        reset_g1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            f = c / 5;
            j = c % 5;
            s = f % 2;
            checks++;
            if (ack_g1 !== ((j == 0) ? 2'(1 << s) : 2'b00)) begin
                errors++; $display("FAIL rr_ack c=%0d got %b", c, ack_g1);
            end
            checks++;
            if (v_g1 !== (j != 0)) begin
                errors++; $display("FAIL rr_valid c=%0d got %b exp %b", c, v_g1, (j != 0));
            end
            if (j != 0) begin
                checks++;
                if ({out_g1, f_g1, l_g1, src_g1} !== {words[s][j-1], j == 1, j == 4, 2'(s)}) begin
                    errors++;
                    $display("FAIL rr_bit c=%0d got out/first/last/src %b%b%b%0d exp src %0d",
                             c, out_g1, f_g1, l_g1, src_g1, s);
                end
            end
            if (c == 19) req_g1 = 2'b00;
        end
        @(negedge clk);
        checks++;
        if ({busy_g1, v_g1} !== 2'b00) begin
            errors++; $display("FAIL rr_end got busy/valid %b%b exp 00", busy_g1, v_g1);
        end
    endtask

    task automatic test_late_request();
        logic [3:0] words [2];
        int j, s;
        words[0] = 4'h3;
        words[1] = 4'hC;
        pulse_reset_g1();
        req_g1   = 2'b01;
        data_g1  = {words[1], words[0]};
        reset_g1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            j = c % 5;
            s = c / 5;
            checks++;
            if (ack_g1 !== ((j == 0) ? 2'(1 << s) : 2'b00)) begin
                errors++; $display("FAIL late_ack c=%0d got %b", c, ack_g1);
            end
            checks++;
            if (v_g1 !== (j != 0)) begin
                errors++; $display("FAIL late_valid c=%0d got %b", c, v_g1);
            end
            if (j != 0) begin
                checks++;
                if ({out_g1, f_g1, l_g1, src_g1} !== {words[s][j-1], j == 1, j == 4, 2'(s)}) begin
                    errors++;
                    $display("FAIL late_bit c=%0d got out/first/last/src %b%b%b%0d exp src %0d",
                             c, out_g1, f_g1, l_g1, src_g1, s);
                end
            end
            if (c == 1) req_g1[0] = 1'b0;
            if (c == 2) req_g1[1] = 1'b1;
            if (c == 6) req_g1[1] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (busy_g1 !== 1'b0) begin
            errors++; $display("FAIL late_end got busy %b exp 0", busy_g1);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        int k;
        w        = 4'h5;
        req_g0   = 2'b01;
        data_g0  = {4'h0, w};
        @(negedge clk);
        reset_g0 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            checks++;
            if (ack_g0 !== ((c % 4 == 0) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL b2b_ack c=%0d got %b", c, ack_g0);
            end
            checks++;
            if (sh_g0 !== (c % 4 != 0)) begin
                errors++; $display("FAIL b2b_sh c=%0d got %b", c, sh_g0);
            end
            checks++;
            if (v_g0 !== (c >= 1)) begin
                errors++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, v_g0, (c >= 1));
            end
            if (c >= 1) begin
                k = (c - 1) % 4;
                checks++;
                if ({out_g0, f_g0, l_g0, src_g0} !== {w[k], k == 0, k == 3, 2'd0}) begin
                    errors++;
                    $display("FAIL b2b_bit c=%0d got out/first/last/src %b%b%b%0d exp %b%b%b0",
                             c, out_g0, f_g0, l_g0, src_g0, w[k], k == 0, k == 3);
                end
            end
            if (c == 12) req_g0 = 2'b00;
        end
    endtask

    task automatic test_reset_midframe();
        pulse_reset_g1();
        req_g1   = 2'b11;
        data_g1  = 8'hCA;
        reset_g1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_g1 !== 2'b01) begin
            errors++; $display("FAIL mid_first_ack got %b exp 01", ack_g1);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sh_g1, v_g1} !== 2'b11) begin
            errors++; $display("FAIL mid_shift got sh/valid %b%b exp 11", sh_g1, v_g1);
        end
        reset_g1 = 1'b0;
        #1;
        checks++;
        if ({v_g1, sh_g1, ack_g1, busy_g1, f_g1, l_g1} !== 7'b0) begin
            errors++;
            $display("FAIL mid_abort got valid/sh/ack/busy/first/last %b%b%b%b%b%b exp 0",
                     v_g1, sh_g1, ack_g1, busy_g1, f_g1, l_g1);
        end
        @(negedge clk);
        reset_g1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack_g1, pin_g1} !== {2'b01, 4'hA}) begin
            errors++; $display("FAIL mid_regrant got ack %b pin %h exp 01 a", ack_g1, pin_g1);
        end
        req_g1 = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_idle();
        req_g1 = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_g1, sh_g1, pin_g1, v_g1} !== 7'b0) begin
                errors++;
                $display("FAIL idle c=%0d got busy/sh/pin/valid %b%b%h%b exp 0",
                         c, busy_g1, sh_g1, pin_g1, v_g1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_late_request();
        test_back_to_back();
        test_reset_midframe();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx_sched.md
# piso_tx_sched

Round-robin transmit scheduler that shares one LSB-first parallel-in/serial-out shift register (`piso`) between up to four requesters. It grants one requester at a time and drives the `piso` load and shift controls through one load cycle and WIDTH-1 shift cycles. It also produces framing strobes aligned to the `piso` serial output. It sits between the parallel word sources and the `piso` instance. `piso.out` and its own reset are wired outside this block.

## Interface
Parameters:
- WIDTH, 4: word width; must match the `piso` instance; legal range 2..16.
- NREQ, 2: number of requesters; legal range 2..4.
- GAP, 1: number of idle cycles forced between frames; legal range 0..3.

Ports:
- clk  in  1  single clock; everything is posedge.
- reset  in  1  asynchronous, active-low (0 = reset).
- req  in  NREQ  request per requester; level; held high until that requester's ack.
- data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]; stable while req[i]=1.
- ack  out  NREQ  one-hot, one-cycle pulse during the LOAD cycle of the granted requester.
- busy  out  1  high whenever the state is not IDLE.
- piso_in  out  WIDTH  drives `piso.in`.
- piso_sh  out  1  drives `piso.sh` (0 = load, 1 = shift).
- bit_valid  out  1  high while `piso.out` carries a frame bit.
- bit_first  out  1  high with the frame's bit 0.
- bit_last  out  1  high with the frame's bit WIDTH-1.
- bit_src  out  2  index of the requester that owns the current bit; valid only while bit_valid=1.

## Operation
- States and their outputs:
  - IDLE: piso_sh=0, piso_in=0.
  - LOAD: piso_sh=0, piso_in=data[grant], ack[grant]=1.
  - SHIFT: piso_sh=1, piso_in=0. Runs WIDTH-1 cycles, tracked by a down-counter.
  - GAP: piso_sh=0, piso_in=0. Runs GAP cycles.
- Arbitration happens on a "decision" edge. Decision edges are:
  - any edge in IDLE;
  - the edge ending the last SHIFT cycle when GAP=0;
  - the edge ending the last GAP cycle.
- On a decision edge:
  - If any req is high, go to LOAD. The grant is the first requester with req=1, searching from (last_grant+1) mod NREQ upward with wrap.
  - If no req is high, go to IDLE.
- Transitions: LOAD → SHIFT. The last SHIFT cycle goes to GAP when GAP>0; otherwise it is a decision edge.
- Grant handling: the grant index is registered at the decision edge and last_grant is updated at the same edge. last_grant resets to NREQ-1, so requester 0 wins first.
- ack is a Moore output of LOAD. The requester may change data or drop req from the cycle after ack onward.
- If req drops before ack, that is a protocol violation. The frame is still sent with whatever data is present in the LOAD cycle.
- Framing strobes are registered one cycle behind the state, matching the `piso` registered output:
  - bit_valid <= LOAD or SHIFT;
  - bit_first <= LOAD;
  - bit_last <= (last SHIFT cycle);
  - bit_src <= grant.
- Reset values: state IDLE, ack=0, busy=0, piso_sh=0, piso_in=0, bit_valid=0, bit_first=0, bit_last=0, bit_src=0, last_grant=NREQ-1.
- Reset mid-frame aborts the frame immediately: no ack, strobes go to 0. The `piso` contents are left as-is and are ignored because bit_valid=0.

## Timing
- Decision edge E0 (in IDLE, with a req high) → LOAD during cycle E0..E1, and ack is high in that cycle.
- Bit k of the word appears on `piso.out` with bit_valid=1 in cycle E(k+1)..E(k+2), for k = 0..WIDTH-1.
- Frame length is WIDTH cycles of bit_valid. Request-to-first-bit latency is 2 edges.
- GAP=0 with pending requests: the next LOAD follows the last SHIFT directly, so bit_valid stays continuous. bit_last of one frame is immediately followed by bit_first of the next.
- GAP=g: exactly g cycles with bit_valid=0 between frames.
- Throughput: one word per WIDTH+GAP cycles.
- A requester that is granted and keeps req high cannot win again while another requester is waiting.

## Test plan
- Reset: hold reset=0 with random req → all outputs at reset values. Release reset with req=2'b01, data0=4'hA, GAP=1 → ack[0] pulse in the first cycle after the decision edge, then bit_valid for 4 cycles. The `piso` out sequence is 0,1,0,1, with bit_first on the first bit and bit_last on the fourth.
- Round robin: req=2'b11, data0=4'h3, data1=4'hC, both held → frames alternate src 0,1,0,1. Each ack lasts exactly 1 cycle, and there is 1 idle cycle between frames.
- Back-to-back: GAP=0, req0 held high, data0=4'h5 → bit_valid stays high continuously. bit_first follows bit_last with no gap, and out repeats 1,0,1,0.
- Late request: req1 rises during a src-0 SHIFT cycle → src-1 LOAD occurs only after the current frame and the gap. The in-flight frame bits are unchanged.
- Reset mid-frame: assert reset=0 during the second SHIFT cycle → bit_valid, piso_sh, ack and busy are 0 in the same cycle. After release, the first grant goes to requester 0.
- Idle: req=0 for 20 cycles → busy=0, piso_sh=0, piso_in=0, bit_valid=0 throughout.
